// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg: FSM state types and word-addressing constants shared by the memory stream server
package mem_stream_pkg;
  typedef enum logic [2:0] {R_IDLE, R_ISSUE, R_CAPT, R_PRESENT, R_ACK} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_ACK} wr_state_t;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_SHIFT = 2;
endpackage

// File: rtl/mem_addr_xlate.sv
// mem_addr_xlate: byte address to SRAM word index with range check against the mapped window
module mem_addr_xlate import mem_stream_pkg::*; #(
  parameter int          MEM_AW    = 12,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic [63:0]       addr,
  output logic [MEM_AW-1:0] idx,
  output logic              in_range
);
  logic [63:0] off;
  assign off = addr - BASE_ADDR;
  assign idx = off[ADDR_SHIFT +: MEM_AW];
  assign in_range = addr >= BASE_ADDR && off < (64'(WORD_BYTES) << MEM_AW);
endmodule

// File: rtl/mem_stream_server.sv
// mem_stream_server: serves word-at-a-time read/write stream handshakes from a 1-cycle-latency SRAM
module mem_stream_server import mem_stream_pkg::*; #(
  parameter int          MEM_AW    = 12,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_enable,
  input  logic [63:0]       read_addr,
  input  logic              finish_read,
  output logic [63:0]       read_ready,
  output logic [31:0]       read_data,
  input  logic              write_enable,
  input  logic [63:0]       write_addr,
  input  logic [31:0]       write_data,
  input  logic              finish_write,
  output logic [63:0]       write_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              addr_err,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);
  rd_state_t r_state, r_next;
  wr_state_t w_state, w_next;
  logic [MEM_AW-1:0] rd_idx, wr_idx;
  logic rd_in, wr_in, rd_ok;
  mem_addr_xlate #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE_ADDR)) u_rd_xlate (
    .addr(read_addr), .idx(rd_idx), .in_range(rd_in)
  );
  mem_addr_xlate #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE_ADDR)) u_wr_xlate (
    .addr(write_addr), .idx(wr_idx), .in_range(wr_in)
  );
  always_comb begin
    r_next = r_state == R_IDLE    ? (read_enable && !write_enable && w_state == W_IDLE ? R_ISSUE : R_IDLE)
           : r_state == R_ISSUE   ? R_CAPT
           : r_state == R_CAPT    ? R_PRESENT
           : r_state == R_PRESENT ? (read_enable ? R_ACK : R_IDLE)
           : finish_read ? R_ISSUE : read_enable ? R_ACK : R_IDLE;
    w_next = w_state == W_IDLE   ? (write_enable && r_state == R_IDLE ? W_COMMIT : W_IDLE)
           : w_state == W_COMMIT ? W_ACK
           : finish_write ? W_COMMIT : write_enable ? W_ACK : W_IDLE;
    mem_ce = (r_state == R_ISSUE && rd_in) || (w_state == W_COMMIT && wr_in);
    mem_we = w_state == W_COMMIT && wr_in;
    mem_addr = w_state == W_COMMIT ? wr_idx : r_state == R_ISSUE ? rd_idx : '0;
    mem_wdata = w_state == W_COMMIT ? write_data : '0;
    read_ready = {63'd0, r_state == R_PRESENT};
    write_ready = {63'd0, w_state == W_COMMIT};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      rd_ok <= 1'b0;
      read_data <= '0;
      addr_err <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      if (r_state == R_ISSUE) rd_ok <= rd_in;
      if (r_state == R_CAPT) read_data <= rd_ok ? mem_rdata : '0;
      if (r_state == R_PRESENT) rd_count <= rd_count + 32'd1;
      if (w_state == W_COMMIT) wr_count <= wr_count + 32'd1;
      if ((r_state == R_CAPT && !rd_ok) || (w_state == W_COMMIT && !wr_in)) addr_err <= 1'b1;
    end
  end
endmodule

// File: doc/mem_stream_server.md
# mem_stream_server

Memory-side responder for the accelerator wrapper's streaming read/write handshake. It turns word-at-a-time requests (byte address plus enable, acknowledged by `finish_*` pulses) into accesses on a single-port synchronous SRAM with 1-cycle read latency. It returns each read word with a one-cycle `read_ready` pulse and commits each write with a one-cycle `write_ready` pulse. It sits directly upstream of the wrapper's WAIT_READ loop and directly downstream of its WAIT_WRITE loop.

## Interface
Parameters:
- `MEM_AW`, 12: SRAM word-address width (4096 words).
- `BASE_ADDR`, 64'd0: byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-low reset.
- `read_enable`  in  1  read channel request.
- `read_addr`  in  64  byte address of the current read word.
- `finish_read`  in  1  wrapper consumed the word; `read_addr` already holds the next address.
- `read_ready`  out  64  bit0 = one-cycle data-valid pulse; bits 63:1 are 0.
- `read_data`  out  32  word returned with `read_ready`.
- `write_enable`  in  1  write channel request.
- `write_addr`  in  64  byte address of the current write word.
- `write_data`  in  32  word to write.
- `finish_write`  in  1  wrapper advanced to the next word.
- `write_ready`  out  64  bit0 = one-cycle commit pulse; bits 63:1 are 0.
- `mem_ce`, `mem_we`  out  1  SRAM chip enable and write enable.
- `mem_addr`  out  MEM_AW  SRAM word index.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data, valid the cycle after a `ce && !we` access.
- `addr_err`  out  1  sticky flag: some access fell out of range.
- `rd_count`, `wr_count`  out  32  completed-word counters.

## Operation
- Address translation: `idx = (addr - BASE_ADDR) >> 2`, using 64-bit unsigned subtraction.
  - The access is in range iff `addr >= BASE_ADDR` and `idx < 2**MEM_AW`.
  - The low 2 address bits are ignored.
- Read FSM states: R_IDLE, R_ISSUE, R_CAPT, R_PRESENT, R_ACK.
  - R_IDLE → R_ISSUE when `read_enable=1` and the write FSM is in W_IDLE.
  - R_ISSUE: drive `mem_ce=1`, `mem_we=0`, `mem_addr=idx(read_addr)`. An out-of-range access drives `mem_ce=0`. Go to R_CAPT.
  - R_CAPT: register `mem_rdata` into `read_data` (0 if out of range, and set `addr_err`). Set the `read_ready` register. Go to R_PRESENT.
  - R_PRESENT: `read_ready=1` for this cycle only. Increment `rd_count`. Go to R_ACK.
  - R_ACK: on `finish_read=1` go to R_ISSUE; on `read_enable=0` go to R_IDLE. If both hold in the same cycle, `finish_read` wins.
  - `read_enable=0` observed in R_ISSUE or R_CAPT lets the in-flight word complete, then the FSM returns to R_IDLE from R_PRESENT.
- Write FSM states: W_IDLE, W_COMMIT, W_ACK.
  - W_IDLE → W_COMMIT when `write_enable=1` and the read FSM is in R_IDLE.
  - W_COMMIT: `mem_ce=mem_we=1`, `mem_addr=idx(write_addr)`, `mem_wdata=write_data`, `write_ready=1` for one cycle, `wr_count` increments. An out-of-range access drives `mem_ce=0` and sets `addr_err`, but `write_ready` still pulses. Go to W_ACK.
  - W_ACK: on `finish_write=1` go to W_COMMIT; on `write_enable=0` go to W_IDLE.
- Arbitration: if both enables rise while both FSMs are idle, write wins. The read request waits until the write FSM is back in W_IDLE.
- The SRAM port is driven only in R_ISSUE and W_COMMIT; in all other states `mem_ce=0`, `mem_we=0`.
- Counters wrap modulo 2^32.

## Timing
- Reset value of every output is 0 (`read_ready`, `read_data`, `write_ready`, `mem_*`, `addr_err`, counters). Both FSMs go to idle.
- Reset asserted mid-transfer aborts it within the same edge. No further SRAM access occurs.
- Read latency: `read_enable` sampled high at edge N → `read_ready` high during cycle N+3.
- Successive reads: `finish_read` sampled at edge M → next `read_ready` during cycle M+3.
- Write latency: `write_enable` sampled at edge N → `write_ready` and the SRAM write during cycle N+1.
- Successive writes: `finish_write` at edge M → next commit during cycle M+1.
- `read_ready` and `write_ready` are never high in consecutive cycles. This guarantees the wrapper never double-captures a word.

## Structure
- Package `mem_stream_pkg`: read/write FSM state enums, `WORD_BYTES=4`, `ADDR_SHIFT=2`.
- One natural sub-module: `mem_addr_xlate`. It is combinational: byte address → {`idx`, `in_range`}, parameterised by `MEM_AW` and `BASE_ADDR`. Instantiate it twice, once for `read_addr` and once for `write_addr`.

## Test plan
- Preload SRAM[0..3]={11,22,33,44}; wrapper-style read of 4 words from 0 with finish pulses → `read_data` 11,22,33,44. Each `read_ready` is one cycle, first at N+3. `rd_count`=4.
- Write 4 words {5,6,7,8} to byte addr 16 → SRAM[4..7]=5..8. `write_ready` at N+1 and at each M+1. `wr_count`=4.
- `BASE_ADDR`=0x1000, read at 0x0FFC and at 0x1000+4*4096 → `read_data`=0, `addr_err`=1, no SRAM access. A subsequent in-range read still works.
- `read_enable` and `write_enable` rise in the same cycle → write commits first. Read `read_ready` appears 3 cycles after the write FSM returns to W_IDLE.
- Drop `read_enable` in R_CAPT → `read_ready` still pulses once, then the FSM is in R_IDLE with no further `mem_ce`.
- Assert reset (`reset`=0) during R_ACK and during W_COMMIT → all outputs 0 next cycle, counters cleared, and the next transfer begins with the N+3 latency.
